// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb_pkg
// Description : Shared definitions for the tri-state bus arbiter: FSM state
//               encoding, default sizing constants and an index-wrap helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

    // Default number of requesters and default tenure limit.
    localparam int c_default_n        = 4;
    localparam int c_default_max_hold = 16;

    // Arbiter FSM encoding (explicit 2-bit width).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    // (idx + 1) mod n, for idx already in 0..n-1.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Searches req starting at
//               rr_ptr and wrapping modulo N; the first set bit wins.
// Ports       : req    [N-1:0]        request vector
//               rr_ptr [clog2(N)-1:0] highest-priority index
//               valid                 any request present
//               idx    [clog2(N)-1:0] winning index (0 when !valid)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter  int N       = 4,
    localparam int c_idx_w = $clog2(N)
) (
    input  logic [N-1:0]       req,
    input  logic [c_idx_w-1:0] rr_ptr,
    output logic               valid,
    output logic [c_idx_w-1:0] idx
);

    logic [c_idx_w-1:0] w_pos;

    // Walk offsets from the farthest to the nearest so the nearest set bit
    // (lowest offset from rr_ptr) is the last assignment and therefore wins.
    always_comb begin
        valid = |req;
        idx   = '0;
        w_pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = c_idx_w'((int'(rr_ptr) + k) % N);
            if (req[w_pos]) begin
                idx = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter for N requesters sharing one tri-state
//               bus. A tenure lasts while the owner holds req, up to MAX_HOLD
//               cycles, and is always followed by one all-off turnaround
//               cycle (TURN) and one arbitration cycle (IDLE).
// Ports       : clk      clock, rising edge
//               rst      synchronous active-high reset
//               req      [N-1:0] level requests
//               grant    [N-1:0] registered one-hot-or-zero driver enables
//               owner    [clog2(N)-1:0] current grantee, 0 when no grant
//               busy     any grant bit high
//               preempt  one-cycle pulse when a tenure is cut by MAX_HOLD
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N        = c_default_n,
    parameter int MAX_HOLD = c_default_max_hold
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 preempt
);

    localparam int                  c_idx_w    = $clog2(N);
    localparam int                  c_hold_w   = $clog2(MAX_HOLD + 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MAX_HOLD);
    localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N-1:0]        r_grant;
    logic [N-1:0]        w_grant_nxt;
    logic [c_idx_w-1:0]  r_owner;
    logic [c_idx_w-1:0]  w_owner_nxt;
    logic [c_idx_w-1:0]  r_rr_ptr;
    logic [c_idx_w-1:0]  w_rr_ptr_nxt;
    logic [c_hold_w-1:0] r_hold;
    logic [c_hold_w-1:0] w_hold_nxt;
    logic                r_preempt;
    logic                w_preempt_nxt;

    logic                w_pick_valid;
    logic [c_idx_w-1:0]  w_pick_idx;
    logic                w_own_req;
    logic                w_own_exit;

    rr_pick #(
        .N(N)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_pick_valid),
        .idx    (w_pick_idx)
    );

    // Only the owner's request is looked at during a tenure; other request
    // changes wait for the next IDLE arbitration.
    assign w_own_req  = req[r_owner];
    assign w_own_exit = !w_own_req || (r_hold == c_hold_max);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_hold    <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_owner   <= w_owner_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_hold    <= w_hold_nxt;
            r_preempt <= w_preempt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid) w_state_nxt = OWN;
            OWN:     if (w_own_exit)   w_state_nxt = TURN;
            TURN:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs. Everything
    // defaults to "bus released", so TURN and IDLE-without-request need
    // no explicit branch.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_nxt   = '0;
        w_owner_nxt   = '0;
        w_hold_nxt    = '0;
        w_preempt_nxt = 1'b0;
        w_rr_ptr_nxt  = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt[w_pick_idx] = 1'b1;
                    w_owner_nxt             = w_pick_idx;
                    // Counter reads 1 during the first OWN cycle.
                    w_hold_nxt              = c_hold_one;
                end
            end
            OWN: begin
                if (w_own_exit) begin
                    w_rr_ptr_nxt  = c_idx_w'(wrap_inc(int'(r_owner), N));
                    // Exiting with req still high can only mean the hold
                    // limit was reached; a req drop suppresses the pulse.
                    w_preempt_nxt = w_own_req;
                end else begin
                    w_grant_nxt = r_grant;
                    w_owner_nxt = r_owner;
                    w_hold_nxt  = r_hold + c_hold_one;
                end
            end
            default: begin
            end
        endcase
    end

    assign grant   = r_grant;
    assign owner   = r_owner;
    assign busy    = |r_grant;
    assign preempt = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Directed and randomised bench for bus_arbiter (N=4,
//               MAX_HOLD=16). Directed vectors carry hand-derived grant /
//               owner / busy / preempt values; the random phase drives a
//               four-driver bus model and tracks contention, turnaround
//               gaps and worst-case wait.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;
    // Longest run of not-granted cycles for a requester holding req: its
    // own TURN and the IDLE before its next grant, plus N-1 full tenures
    // of (IDLE + MAX_HOLD + TURN).
    localparam int c_starve = (N - 1) * (MAX_HOLD + 2) + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [1:0]   owner;
    logic         busy;
    logic         preempt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .preempt (preempt)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [N-1:0] g,
                           input int o, input logic p);
        chk({tag, "/grant"},   int'(grant),   int'(g));
        chk({tag, "/owner"},   int'(owner),   o);
        chk({tag, "/busy"},    int'(busy),    int'(g != '0));
        chk({tag, "/preempt"}, int'(preempt), int'(p));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    int ord [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] g_exp;

    // Random-phase bookkeeping
    int served [N];
    int want   [N];
    int wait_c [N];
    int max_wait, viol_multi, viol_busy, viol_owner, viol_fallrise;
    int viol_gap, viol_preempt, grant_cycles, preempt_cnt, zero_run;
    logic [N-1:0] prev_g;
    logic [N-1:0] owner_hot;
    bit seen_grant;

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        chk_out("reset", 4'b0000, 0, 1'b0);
        step();
        chk_out("idle_noreq", 4'b0000, 0, 1'b0);

        // ---------------- single requester, req drop ----------------
        req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            step();
            chk_out("single", 4'b0001, 0, 1'b0);
        end
        req = 4'b0000;
        step();
        chk_out("drop_turn", 4'b0000, 0, 1'b0);
        step();
        chk_out("drop_idle", 4'b0000, 0, 1'b0);
        req = 4'b0010;                  // rr_ptr is now 1
        step();
        chk_out("second", 4'b0010, 1, 1'b0);
        req = 4'b0000;
        step();
        step();

        // ---------------- all requesting, MAX_HOLD rotation ----------------
        do_reset();
        req = 4'b1111;
        for (int e = 0; e < 5; e++) begin
            g_exp = 4'(1 << ord[e]);
            for (int c = 0; c < MAX_HOLD; c++) begin
                step();
                chk_out("rot_hold", g_exp, ord[e], 1'b0);
            end
            if (e < 4) begin
                step();
                chk_out("rot_turn", 4'b0000, 0, 1'b1);
                step();
                chk_out("rot_idle", 4'b0000, 0, 1'b0);
            end
        end
        req = 4'b0000;
        step();
        chk_out("rot_end", 4'b0000, 0, 1'b0);
        step();

        // ---------------- owner 2, then 3, then 1 ----------------
        do_reset();
        req = 4'b0100;
        step();
        chk_out("rr_own2", 4'b0100, 2, 1'b0);
        req = 4'b1110;                  // others rise mid-tenure: ignored
        step();
        chk_out("rr_own2_hold", 4'b0100, 2, 1'b0);
        req = 4'b1010;
        step();
        chk_out("rr_turn", 4'b0000, 0, 1'b0);
        step();
        chk_out("rr_idle", 4'b0000, 0, 1'b0);
        step();
        chk_out("rr_own3", 4'b1000, 3, 1'b0);
        req = 4'b0010;
        step();
        step();
        step();
        chk_out("rr_own1", 4'b0010, 1, 1'b0);
        req = 4'b0000;
        step();
        step();

        // ---------------- reset during OWN ----------------
        do_reset();
        req = 4'b0100;
        step();
        step();
        chk_out("rst_own2", 4'b0100, 2, 1'b0);
        rst = 1'b1;
        step();
        chk_out("rst_mid", 4'b0000, 0, 1'b0);
        rst = 1'b0;
        req = 4'b0110;
        step();
        chk_out("rst_after", 4'b0010, 1, 1'b0);
        req = 4'b0000;
        step();
        step();

        // ---------------- req drop coincides with hold limit ----------------
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < MAX_HOLD; c++) step();
        chk_out("coinc_last", 4'b0001, 0, 1'b0);
        req = 4'b0000;
        step();
        chk_out("coinc_turn", 4'b0000, 0, 1'b0);
        step();
        chk_out("coinc_idle", 4'b0000, 0, 1'b0);

        // ---------------- lone requester preempted, re-granted ----------------
        req = 4'b0001;
        for (int c = 0; c < MAX_HOLD; c++) step();
        chk_out("lone_last", 4'b0001, 0, 1'b0);
        step();
        chk_out("lone_turn", 4'b0000, 0, 1'b1);
        step();
        chk_out("lone_idle", 4'b0000, 0, 1'b0);
        step();
        chk_out("lone_regrant", 4'b0001, 0, 1'b0);
        req = 4'b0000;
        step();
        step();

        // ---------------- random bus traffic ----------------
        do_reset();
        max_wait = 0; viol_multi = 0; viol_busy = 0; viol_owner = 0;
        viol_fallrise = 0; viol_gap = 0; viol_preempt = 0;
        grant_cycles = 0; preempt_cnt = 0; zero_run = 0;
        prev_g = '0; seen_grant = 1'b0;
        for (int i = 0; i < N; i++) begin
            served[i] = 0; want[i] = 0; wait_c[i] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            step();
            // Each set grant bit is one enabled tri-state driver.
            if ($countones(grant) > 1) viol_multi++;
            if (busy !== (grant != '0)) viol_busy++;
            owner_hot = 4'(1) << owner;
            if (grant == '0) begin
                if (owner != 2'd0) viol_owner++;
            end else if (grant != owner_hot) begin
                viol_owner++;
            end
            if (prev_g != '0 && grant != '0 && grant != prev_g) viol_fallrise++;
            if (grant != '0) begin
                if (prev_g == '0 && seen_grant && zero_run < 2) viol_gap++;
                zero_run   = 0;
                seen_grant = 1'b1;
                grant_cycles++;
            end else begin
                zero_run++;
            end
            if (preempt) begin
                preempt_cnt++;
                if (grant != '0) viol_preempt++;
            end
            prev_g = grant;
            for (int i = 0; i < N; i++) begin
                if (req[i] && !grant[i]) begin
                    wait_c[i]++;
                    if (wait_c[i] > max_wait) max_wait = wait_c[i];
                end else begin
                    wait_c[i] = 0;
                end
                if (req[i]) begin
                    if (grant[i]) begin
                        served[i]++;
                        if (served[i] >= want[i]) req[i] = 1'b0;
                    end
                end else if ($urandom_range(3) == 0) begin
                    req[i]    = 1'b1;
                    want[i]   = int'($urandom_range(24, 1));
                    served[i] = 0;
                end
            end
        end
        chk("bus_contention",   viol_multi,    0);
        chk("busy_consistency", viol_busy,     0);
        chk("owner_consistency", viol_owner,   0);
        chk("fall_then_rise",   viol_fallrise, 0);
        chk("turnaround_gap",   viol_gap,      0);
        chk("preempt_in_grant", viol_preempt,  0);
        chk("starvation",       int'(max_wait <= c_starve), 1);
        chk("traffic_seen",     int'(grant_cycles > 1000), 1);
        chk("preempt_seen",     int'(preempt_cnt > 0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
